// File: rtl/serial_add_sub_pkg.sv
// rtl/serial_add_sub_pkg.sv - shared state and mode encodings for the bit-serial add/sub unit
package serial_add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/add_sub_cell.sv
// rtl/add_sub_cell.sv - combinational 1-bit full adder / full subtractor cell
module add_sub_cell
    import serial_add_sub_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cbin,
    input  logic mode,
    output logic s,
    output logic cbout
);

    logic ax;

    // Inverting the minuend turns the carry equation into the borrow equation.
    assign ax    = (mode == MODE_SUB) ? ~a : a;
    assign s     = a ^ b ^ cbin;
    assign cbout = (ax & b) | (cbin & (ax ^ b));

endmodule

// File: rtl/serial_add_sub.sv
// rtl/serial_add_sub.sv - LSB-first bit-serial adder/subtractor with start/done handshake
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cbout,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_shift;
    logic [CW-1:0]    cnt;
    logic             cb, mode_q, a_msb, b_msb;
    logic             s, cb_next, accept, last;

    add_sub_cell u_cell (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .cbin  (cb),
        .mode  (mode_q),
        .s     (s),
        .cbout (cb_next)
    );

    assign accept    = start && (state == IDLE || state == DONE);
    assign last      = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
    assign res_shift = (res_sh >> 1) | (WIDTH'(s) << (WIDTH - 1));
    assign busy      = (state == SHIFT);
    assign done      = (state == DONE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last) state_next = DONE;
            DONE:    state_next = start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            cnt      <= '0;
            cb       <= 1'b0;
            mode_q   <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            result   <= '0;
            cbout    <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            mode_q <= mode;
            cb     <= cin;
            cnt    <= '0;
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
        end else if (state == SHIFT) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_shift;
            cb     <= cb_next;
            cnt    <= cnt + CW'(1);
            // The last computed bit is the sign bit, so overflow is decided from s here.
            if (last) begin
                result   <= res_shift;
                cbout    <= cb_next;
                overflow <= ((a_msb ^ b_msb) == mode_q) && (s != a_msb);
            end
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// tb/tb_serial_add_sub.sv - table-driven self-checking bench for serial_add_sub (WIDTH 8 and 1)
module tb_serial_add_sub;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode = 1'b0;
    logic       cin = 1'b0;
    logic       start8 = 1'b0, start1 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       a1 = 1'b0, b1 = 1'b0;
    logic       busy8, done8, cbout8, ov8;
    logic [7:0] res8;
    logic       busy1, done1, cbout1, ov1;
    logic       res1;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_add_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode), .cin(cin),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .result(res8),
        .cbout(cbout8), .overflow(ov8)
    );

    serial_add_sub #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode), .cin(cin),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .result(res1),
        .cbout(cbout1), .overflow(ov1)
    );

    typedef struct {
        bit         w1;
        bit         m;
        bit         c;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        bit         co;
        bit         ov;
        int         lat;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts at a negedge, returns at the negedge where done is seen (or after the bound).
    task automatic do_op(input bit w1, input bit m, input bit c, input logic [7:0] a, input logic [7:0] b,
                         output int lat, output logic [7:0] r, output logic co, output logic ov);
        mode = m;
        cin  = c;
        if (w1) begin a1 = a[0]; b1 = b[0]; start1 = 1'b1; end
        else    begin a8 = a;    b8 = b;    start8 = 1'b1; end
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            start1 = 1'b0;
            start8 = 1'b0;
        end while (!(w1 ? done1 : done8) && lat < 20);
        r  = w1 ? {7'b0, res1} : res8;
        co = w1 ? cbout1 : cbout8;
        ov = w1 ? ov1 : ov8;
    endtask

    initial begin
        int         lat, k;
        logic [7:0] r;
        logic       co, ov;
        bit         seen;

        vecs[0]  = '{1, 1, 0, 8'h0, 8'h0, 8'h0, 0, 0, 2};
        vecs[1]  = '{1, 1, 1, 8'h0, 8'h0, 8'h1, 1, 0, 2};
        vecs[2]  = '{1, 1, 0, 8'h0, 8'h1, 8'h1, 1, 1, 2};
        vecs[3]  = '{1, 1, 1, 8'h0, 8'h1, 8'h0, 1, 0, 2};
        vecs[4]  = '{1, 1, 0, 8'h1, 8'h0, 8'h1, 0, 0, 2};
        vecs[5]  = '{1, 1, 1, 8'h1, 8'h0, 8'h0, 0, 1, 2};
        vecs[6]  = '{1, 1, 0, 8'h1, 8'h1, 8'h0, 0, 0, 2};
        vecs[7]  = '{1, 1, 1, 8'h1, 8'h1, 8'h1, 1, 0, 2};
        vecs[8]  = '{0, 1, 0, 8'h05, 8'h03, 8'h02, 0, 0, 9};
        vecs[9]  = '{0, 1, 0, 8'h03, 8'h05, 8'hFE, 1, 0, 9};
        vecs[10] = '{0, 0, 0, 8'h7F, 8'h01, 8'h80, 0, 1, 9};
        vecs[11] = '{0, 0, 0, 8'hFF, 8'h01, 8'h00, 1, 0, 9};
        vecs[12] = '{0, 1, 0, 8'h80, 8'h01, 8'h7F, 0, 1, 9};
        vecs[13] = '{0, 0, 1, 8'h10, 8'h20, 8'h31, 0, 0, 9};
        vecs[14] = '{0, 1, 1, 8'h00, 8'h00, 8'hFF, 1, 0, 9};

        repeat (2) @(negedge clk);
        check("reset_busy", busy8, 0);
        check("reset_done", done8, 0);
        check("reset_result", res8, 0);
        check("reset_cbout", cbout8, 0);
        check("reset_overflow", ov8, 0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            do_op(vecs[i].w1, vecs[i].m, vecs[i].c, vecs[i].a, vecs[i].b, lat, r, co, ov);
            check($sformatf("vec%0d_result", i), r, vecs[i].r);
            check($sformatf("vec%0d_cbout", i), co, vecs[i].co);
            check($sformatf("vec%0d_overflow", i), ov, vecs[i].ov);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
        end
        @(negedge clk);
        check("done_one_cycle", done8, 0);

        // Result must hold through IDLE and through the following SHIFT phase.
        do_op(0, 0, 0, 8'h11, 8'h22, lat, r, co, ov);
        check("pre_hold_result", r, 8'h33);
        repeat (3) @(negedge clk);
        check("hold_idle_result", res8, 8'h33);
        mode = 1'b1; cin = 1'b0; a8 = 8'h05; b8 = 8'h03; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        check("shift_busy", busy8, 1);
        check("hold_shift_result", res8, 8'h33);
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'h77; mode = 1'b0; cin = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        k = 0;
        while (!done8 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("ignore_done", done8, 1);
        check("ignore_result", res8, 8'h02);
        check("ignore_cbout", cbout8, 0);
        check("ignore_overflow", ov8, 0);
        @(negedge clk);

        // Back-to-back: second start issued in the DONE cycle of the first.
        do_op(0, 0, 0, 8'h10, 8'h01, lat, r, co, ov);
        check("b2b_first_result", r, 8'h11);
        do_op(0, 1, 0, 8'h20, 8'h01, lat, r, co, ov);
        check("b2b_second_result", r, 8'h1F);
        check("b2b_second_latency", lat, 9);

        // Asynchronous reset in the middle of SHIFT.
        @(negedge clk);
        mode = 1'b0; cin = 1'b0; a8 = 8'h40; b8 = 8'h02; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy8, 0);
        check("abort_done", done8, 0);
        check("abort_result", res8, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done8) seen = 1'b1;
        end
        check("abort_no_done", seen, 0);
        do_op(0, 0, 0, 8'h40, 8'h02, lat, r, co, ov);
        check("after_reset_result", r, 8'h42);
        check("after_reset_latency", lat, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
